bus_burst_slave: RTL and testbench
==================================

Name: bus_burst_slave

Overview:
Memory-mapped burst slave on the shared system bus. It is the downstream consumer of the ramDmaCi DMA master's bus transactions: it answers DMA read bursts with data beats and absorbs DMA write bursts into an internal word memory. It models busy stalls and error terminations so the DMA's bus-side FSM can be exercised in system simulation.

Parameters:
BASE_ADDRESS, 32'h0000_0000, byte base address of the decoded window; must be aligned to 4*2^ADDR_WIDTH.
ADDR_WIDTH, 10, log2 of memory depth in 32-bit words. The window spans 4*2^ADDR_WIDTH bytes.
READ_LATENCY, 2, cycles from accepted begin_transaction to the first read beat; range 1..15.
BUSY_PERIOD, 0, during writes, assert busy for 1 cycle after every BUSY_PERIOD accepted words; 0 disables stalls.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
busIn_begin_transaction  in  1  master starts a transaction this cycle
busIn_address_data  in  32  byte address on begin, write data otherwise
busIn_burst_size  in  8  beats minus 1, sampled on begin
busIn_read_n_write  in  1  1 = read, sampled on begin
busIn_byte_enables  in  4  write byte lanes, sampled on begin
busIn_data_valid  in  1  master write beat valid
busIn_end_transaction  in  1  master terminates the transaction
busIn_busy  in  1  master cannot accept a read beat this cycle
busOut_address_data  out  32  read data
busOut_data_valid  out  1  read beat valid
busOut_end_transaction  out  1  slave ends the read burst
busOut_busy  out  1  slave stalls the write beat
busOut_error  out  1  transaction error, 1-cycle pulse

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; FSM goes to IDLE; counters cleared. Memory contents are not reset. Reset mid-burst aborts the burst immediately; no further writes occur.
- Word index = address[ADDR_WIDTH+1:2]; address[1:0] is ignored.
- Hit = (address[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]).
- States: IDLE, CHECK, LAT, READ, RD_END, WRITE, ERR.
- IDLE:
  - On begin_transaction with hit, latch word index, beats = burst_size+1, read_n_write and byte_enables; go to CHECK.
  - On a miss, remain in IDLE and keep all outputs at 0, so other slaves can respond.
- CHECK (1 cycle):
  - If index + beats > 2^ADDR_WIDTH, go to ERR. Compute this check at ADDR_WIDTH+2 bits so it cannot wrap.
  - Otherwise, a read goes to LAT and a write goes to WRITE.
- LAT: wait until READ_LATENCY cycles have elapsed since begin, counting CHECK; then go to READ.
- READ: drive data_valid=1 and address_data=mem[index].
  - A beat is consumed on a cycle with busIn_busy=0; then index and the beat count advance.
  - While busIn_busy=1, hold the same data and valid.
  - After the last beat is consumed, go to RD_END.
  - busIn_end_transaction during LAT or READ aborts the burst to IDLE next cycle, with outputs 0 and no error.
- RD_END (1 cycle): end_transaction=1, data_valid=0, address_data=0; then IDLE.
- WRITE:
  - Each cycle with busIn_data_valid=1 and busOut_busy=0 writes busIn_address_data into mem[index] under the latched byte enables, then advances index.
  - Beats presented while busy=1 are not written; the master must hold them.
  - Beats beyond the burst count are discarded. Any discard raises a sticky overrun flag.
  - busIn_end_transaction ends the write. If the overrun flag is set, go to ERR; otherwise go to IDLE.
  - A beat with data_valid and end_transaction in the same cycle is written before ending.
- Busy injection: when BUSY_PERIOD>0, busOut_busy=1 for exactly the cycle following every BUSY_PERIOD-th accepted write word, except after the final word.
- ERR (1 cycle): error=1, all other outputs 0; then IDLE.
- begin_transaction outside IDLE is ignored.
- Read-during-write to the same word cannot occur, because the slave handles one transaction at a time.
- Memory is a synchronous-read RAM. The READ data path registers the output so that data is valid in the cycle data_valid=1.

Optional Feature:
BUS_SLAVE_ERROR_INJECT_EN
- Defined: adds two inputs, errInject_enable (1 bit) and errInject_beat (8 bits), both sampled on begin.
  - On a read with errInject_enable=1, beats 0..errInject_beat-1 are delivered normally.
  - In the cycle that beat errInject_beat would be driven, the slave asserts error=1 with data_valid=0 for 1 cycle, then returns to IDLE without end_transaction.
  - If errInject_beat >= beats, injection does not occur.
- Undefined: the ports do not exist, and reads never error except through the range check.

Test Plan:
1. Write burst at 0x0000_0030, burst_size=7, BE=4'hF, data 1..8; then read burst at the same address with READ_LATENCY=2 -> first data_valid 2 cycles after begin; beats 1..8; end_transaction pulses one cycle after beat 8.
2. Read burst_size=3 with busIn_busy high on beat 1 for 2 cycles -> beat 1 data held 3 cycles; total data_valid cycles = 6; beat order unchanged.
3. BUSY_PERIOD=4, write 8 words with the master holding data while busy -> busy pulses after words 4 only; mem holds all 8 words in order.
4. Write with BE=4'b0011 of 0xAABBCCDD over 0x11223344 -> word reads 0x1122CCDD.
5. Begin at word index 1020 with burst_size=7 (ADDR_WIDTH=10) -> error pulse 2 cycles after begin; no data beats; memory unchanged. A miss address 0x1000_0000 -> all outputs remain 0.
6. With BUS_SLAVE_ERROR_INJECT_EN, read burst_size=7 with errInject_beat=3 -> beats 0..2 valid; error on the 4th beat cycle; no end_transaction. Assert reset mid-WRITE -> outputs 0 immediately; later words not written.

Source files
------------

// File: rtl/bus_burst_slave.sv
// bus_burst_slave: burst word-memory slave answering DMA read/write bursts; BUS_SLAVE_ERROR_INJECT_EN adds read error injection.
// Latency: first read beat max(READ_LATENCY,2) cycles after begin; write beats accepted from the cycle after CHECK.
// Backpressure: read beat held while busIn_busy; write beat stalled one cycle after every BUSY_PERIOD words.
module bus_burst_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = 2,
  parameter int          BUSY_PERIOD  = 0
) (
  input  logic        clock,
  input  logic        reset,
`ifdef BUS_SLAVE_ERROR_INJECT_EN
  input  logic        errInject_enable,
  input  logic [7:0]  errInject_beat,
`endif
  input  logic        busIn_begin_transaction,
  input  logic [31:0] busIn_address_data,
  input  logic [7:0]  busIn_burst_size,
  input  logic        busIn_read_n_write,
  input  logic [3:0]  busIn_byte_enables,
  input  logic        busIn_data_valid,
  input  logic        busIn_end_transaction,
  input  logic        busIn_busy,
  output logic [31:0] busOut_address_data,
  output logic        busOut_data_valid,
  output logic        busOut_end_transaction,
  output logic        busOut_busy,
  output logic        busOut_error
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Range check width must hold both the index and a 256-beat count without wrapping.
  localparam int CW = (ADDR_WIDTH + 2 > 10) ? ADDR_WIDTH + 2 : 10;
  localparam int LAT_CYC = (READ_LATENCY > 2) ? READ_LATENCY - 3 : 0;
  localparam logic [15:0] PER_LAST = 16'(BUSY_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, CHECK, LAT, READ, RD_END, WRITE, ERR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx, rd_idx;
  logic [8:0]            beats_left;
  logic                  rnw;
  logic [3:0]            be;
  logic                  overrun;
  logic                  busy_q;
  logic [3:0]            lat_cnt;
  logic [15:0]           per_cnt;
  logic                  hit, range_bad, inj_hit;
  logic                  rd_take, wr_acc, wr_en, wr_drop;
  logic [CW-1:0]         span;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           mem_q;

  assign hit       = (busIn_address_data[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign span      = CW'(idx) + CW'(beats_left);
  assign range_bad = (span > CW'(DEPTH));

  assign rd_take = (state == READ) && !busIn_busy && !inj_hit;
  assign wr_acc  = (state == WRITE) && busIn_data_valid && !busy_q;
  assign wr_en   = wr_acc && (beats_left != 9'd0);
  assign wr_drop = wr_acc && (beats_left == 9'd0);
  // Fetch one word ahead so the registered RAM output lines up with the beat being driven.
  assign rd_idx  = rd_take ? idx + ADDR_WIDTH'(1) : idx;

`ifdef BUS_SLAVE_ERROR_INJECT_EN
  logic       inj_en;
  logic [7:0] inj_beat;
  logic [7:0] beat_num;

  assign inj_hit = (state == READ) && inj_en && (beat_num == inj_beat);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inj_en   <= 1'b0;
      inj_beat <= '0;
      beat_num <= '0;
    end else if (state == IDLE && busIn_begin_transaction && hit) begin
      inj_en   <= errInject_enable && busIn_read_n_write;
      inj_beat <= errInject_beat;
      beat_num <= '0;
    end else if (rd_take) begin
      beat_num <= beat_num + 8'd1;
    end
  end
`else
  assign inj_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      beats_left <= '0;
      rnw        <= 1'b0;
      be         <= '0;
      overrun    <= 1'b0;
      busy_q     <= 1'b0;
      lat_cnt    <= '0;
      per_cnt    <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (busIn_begin_transaction && hit) begin
            idx        <= busIn_address_data[ADDR_WIDTH+1:2];
            beats_left <= {1'b0, busIn_burst_size} + 9'd1;
            rnw        <= busIn_read_n_write;
            be         <= busIn_byte_enables;
            overrun    <= 1'b0;
            per_cnt    <= '0;
          end
        end
        CHECK: lat_cnt <= 4'(LAT_CYC);
        LAT: begin
          if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
        end
        READ: begin
          if (rd_take) begin
            idx        <= idx + ADDR_WIDTH'(1);
            beats_left <= beats_left - 9'd1;
          end
        end
        WRITE: begin
          if (wr_en) begin
            idx        <= idx + ADDR_WIDTH'(1);
            beats_left <= beats_left - 9'd1;
            if (BUSY_PERIOD > 0) begin
              if (per_cnt == PER_LAST) begin
                per_cnt <= '0;
                busy_q  <= (beats_left != 9'd1);
              end else begin
                per_cnt <= per_cnt + 16'd1;
              end
            end
          end
          if (wr_drop) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (busIn_begin_transaction && hit) state_nxt = CHECK;
      CHECK: begin
        if (range_bad)              state_nxt = ERR;
        else if (!rnw)              state_nxt = WRITE;
        else if (READ_LATENCY > 2)  state_nxt = LAT;
        else                        state_nxt = READ;
      end
      LAT: begin
        if (busIn_end_transaction)  state_nxt = IDLE;
        else if (lat_cnt == 4'd0)   state_nxt = READ;
      end
      READ: begin
        if (busIn_end_transaction || inj_hit)            state_nxt = IDLE;
        else if (!busIn_busy && beats_left == 9'd1)      state_nxt = RD_END;
      end
      RD_END: state_nxt = IDLE;
      WRITE: begin
        if (busIn_end_transaction) state_nxt = (overrun || wr_drop) ? ERR : IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busOut_data_valid      = (state == READ) && !inj_hit;
    busOut_address_data    = busOut_data_valid ? mem_q : 32'h0;
    busOut_end_transaction = (state == RD_END);
    busOut_busy            = (state == WRITE) && busy_q;
    busOut_error           = (state == ERR) || inj_hit;
  end

  // Word memory: contents survive reset, byte lanes written independently.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= busIn_address_data[8*b +: 8];
      end
    end
    mem_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_bus_burst_slave.sv
// Self-checking bench for bus_burst_slave: shadow memory model feeds an expected-beat queue compared against observed read beats.
module tb_bus_burst_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        busIn_begin_transaction;
  logic [31:0] busIn_address_data;
  logic [7:0]  busIn_burst_size;
  logic        busIn_read_n_write;
  logic [3:0]  busIn_byte_enables;
  logic        busIn_data_valid;
  logic        busIn_end_transaction;
  logic        busIn_busy;
  logic [31:0] busOut_address_data;
  logic        busOut_data_valid;
  logic        busOut_end_transaction;
  logic        busOut_busy;
  logic        busOut_error;
`ifdef BUS_SLAVE_ERROR_INJECT_EN
  logic        errInject_enable;
  logic [7:0]  errInject_beat;
`endif

  always #5 clock = ~clock;

  bus_burst_slave #(
    .BASE_ADDRESS (32'h0000_0000),
    .ADDR_WIDTH   (10),
    .READ_LATENCY (2),
    .BUSY_PERIOD  (4)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
`ifdef BUS_SLAVE_ERROR_INJECT_EN
    .errInject_enable        (errInject_enable),
    .errInject_beat          (errInject_beat),
`endif
    .busIn_begin_transaction (busIn_begin_transaction),
    .busIn_address_data      (busIn_address_data),
    .busIn_burst_size        (busIn_burst_size),
    .busIn_read_n_write      (busIn_read_n_write),
    .busIn_byte_enables      (busIn_byte_enables),
    .busIn_data_valid        (busIn_data_valid),
    .busIn_end_transaction   (busIn_end_transaction),
    .busIn_busy              (busIn_busy),
    .busOut_address_data     (busOut_address_data),
    .busOut_data_valid       (busOut_data_valid),
    .busOut_end_transaction  (busOut_end_transaction),
    .busOut_busy             (busOut_busy),
    .busOut_error            (busOut_error)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [1024];
  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  logic [31:0] wr_q [$];
  int          wr_stalls [$];
  logic        wr_err;
  int          rd_first, rd_valid_cycles, rd_last_valid, rd_end_cycle, rd_err_cycle, rd_hold_bad;

  task automatic clear_inputs;
    busIn_begin_transaction = 1'b0;
    busIn_address_data      = '0;
    busIn_burst_size        = '0;
    busIn_read_n_write      = 1'b0;
    busIn_byte_enables      = '0;
    busIn_data_valid        = 1'b0;
    busIn_end_transaction   = 1'b0;
    busIn_busy              = 1'b0;
  endtask

  // Master write burst of wr_q; holds each word while the slave signals busy.
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be_i);
    int n, i, guard, widx;
    n = wr_q.size(); i = 0; guard = 0; widx = int'(addr[11:2]);
    wr_stalls.delete();
    @(negedge clock);
    busIn_begin_transaction = 1'b1; busIn_address_data = addr; busIn_burst_size = 8'(n - 1);
    busIn_read_n_write = 1'b0; busIn_byte_enables = be_i;
    @(negedge clock);
    busIn_begin_transaction = 1'b0; busIn_address_data = '0;
    while (i < n && guard < 100) begin
      @(negedge clock);
      guard++;
      busIn_data_valid   = 1'b1;
      busIn_address_data = wr_q[i];
      if (busOut_busy) begin
        wr_stalls.push_back(i);
        busIn_end_transaction = 1'b0;
      end else begin
        busIn_end_transaction = (i == n - 1);
        for (int b = 0; b < 4; b++)
          if (be_i[b]) model_mem[widx + i][8*b +: 8] = wr_q[i][8*b +: 8];
        i++;
      end
    end
    @(negedge clock);
    wr_err = busOut_error;
    clear_inputs();
    wr_q.delete();
  endtask

  // Master read burst; expected beats enter the scoreboard as the request is issued.
  task automatic bus_read(input logic [31:0] addr, input int n, input int n_exp,
                          input int busy_beat, input int busy_len);
    int widx, c, beat, held;
    logic busy_now, prev_busy, done;
    logic [31:0] prev_dat;
    widx = int'(addr[11:2]);
    for (int k = 0; k < n_exp; k++) exp_q.push_back(model_mem[widx + k]);
    rd_first = -1; rd_valid_cycles = 0; rd_last_valid = -1; rd_end_cycle = -1;
    rd_err_cycle = -1; rd_hold_bad = 0; prev_dat = '0;
    @(negedge clock);
    busIn_begin_transaction = 1'b1; busIn_address_data = addr; busIn_burst_size = 8'(n - 1);
    busIn_read_n_write = 1'b1;
    @(negedge clock);
    busIn_begin_transaction = 1'b0; busIn_address_data = '0;
    c = 1; beat = 0; held = 0; prev_busy = 1'b0; done = 1'b0;
    while (!done && c < 60) begin
      busy_now = 1'b0;
      if (busOut_data_valid) begin
        if (rd_first < 0) rd_first = c;
        rd_valid_cycles++;
        rd_last_valid = c;
        if (prev_busy && busOut_address_data !== prev_dat) rd_hold_bad++;
        busy_now = (beat == busy_beat) && (held < busy_len);
        if (busy_now) held++;
        else begin
          obs_q.push_back(busOut_address_data);
          beat++;
        end
        prev_dat = busOut_address_data;
      end
      prev_busy  = busy_now;
      busIn_busy = busy_now;
      if (busOut_end_transaction) begin rd_end_cycle = c; done = 1'b1; end
      if (busOut_error)           begin rd_err_cycle = c; done = 1'b1; end
      @(negedge clock);
      c++;
    end
    busIn_busy = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({busOut_data_valid, busOut_end_transaction, busOut_busy, busOut_error} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {busOut_data_valid, busOut_end_transaction, busOut_busy, busOut_error});
    end
    n_cmp++;
    if (busOut_address_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", busOut_address_data);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_write_read;
    logic [31:0] e, o;
    for (int k = 1; k <= 8; k++) wr_q.push_back(32'(k));
    bus_write(32'h0000_0030, 4'hF);
    n_cmp++;
    if (wr_err !== 1'b0) begin n_bad++; $display("FAIL t1_wr_error: got %b expected 0", wr_err); end
    bus_read(32'h0000_0030, 8, 8, -1, 0);
    n_cmp++;
    if (rd_first !== 2) begin n_bad++; $display("FAIL t1_latency: got %0d expected 2", rd_first); end
    n_cmp++;
    if (rd_valid_cycles !== 8) begin n_bad++; $display("FAIL t1_valid_cycles: got %0d expected 8", rd_valid_cycles); end
    n_cmp++;
    if (rd_end_cycle !== 10) begin n_bad++; $display("FAIL t1_end_cycle: got %0d expected 10", rd_end_cycle); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t1_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t1_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read_busy;
    logic [31:0] e, o;
    bus_read(32'h0000_0030, 4, 4, 1, 2);
    n_cmp++;
    if (rd_valid_cycles !== 6) begin n_bad++; $display("FAIL t2_valid_cycles: got %0d expected 6", rd_valid_cycles); end
    n_cmp++;
    if (rd_hold_bad !== 0) begin n_bad++; $display("FAIL t2_hold: got %0d changes expected 0", rd_hold_bad); end
    n_cmp++;
    if (rd_end_cycle !== 8) begin n_bad++; $display("FAIL t2_end_cycle: got %0d expected 8", rd_end_cycle); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t2_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t2_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_busy_inject;
    logic [31:0] e, o;
    for (int k = 0; k < 8; k++) wr_q.push_back(32'hC0DE_0000 + 32'(k));
    bus_write(32'h0000_0100, 4'hF);
    n_cmp++;
    if (wr_stalls.size() !== 1) begin n_bad++; $display("FAIL t3_stall_count: got %0d expected 1", wr_stalls.size()); end
    else begin
      n_cmp++;
      if (wr_stalls[0] !== 4) begin n_bad++; $display("FAIL t3_stall_pos: got %0d expected 4", wr_stalls[0]); end
    end
    bus_read(32'h0000_0100, 8, 8, -1, 0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t3_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t3_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_byte_enable;
    logic [31:0] e, o;
    wr_q.push_back(32'h1122_3344);
    bus_write(32'h0000_0190, 4'hF);
    wr_q.push_back(32'hAABB_CCDD);
    bus_write(32'h0000_0190, 4'b0011);
    bus_read(32'h0000_0190, 1, 1, -1, 0);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_bad++; $display("FAIL t4_beats: got %0d expected 1", obs_q.size()); end
    else begin
      n_cmp++;
      if (obs_q[0] !== 32'h1122_CCDD) begin n_bad++; $display("FAIL t4_merge: got %h expected 1122ccdd", obs_q[0]); end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t4_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_range_error_and_miss;
    logic [31:0] e, o;
    int err_first, err_cnt, other;
    for (int k = 0; k < 4; k++) wr_q.push_back(32'h5A5A_0000 + 32'(k));
    bus_write(32'h0000_0FF0, 4'hF);
    err_first = -1; err_cnt = 0; other = 0;
    @(negedge clock);
    busIn_begin_transaction = 1'b1; busIn_address_data = 32'h0000_0FF0; busIn_burst_size = 8'd7;
    busIn_read_n_write = 1'b0; busIn_byte_enables = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      busIn_begin_transaction = 1'b0;
      if (busOut_error) begin err_cnt++; if (err_first < 0) err_first = c; end
      if (busOut_data_valid || busOut_end_transaction || busOut_busy || busOut_address_data != 32'h0) other++;
      busIn_data_valid      = (c <= 5);
      busIn_address_data    = 32'hDEAD_0000 + 32'(c);
      busIn_end_transaction = (c == 5);
    end
    clear_inputs();
    n_cmp++;
    if (err_first !== 2) begin n_bad++; $display("FAIL t5_err_cycle: got %0d expected 2", err_first); end
    n_cmp++;
    if (err_cnt !== 1) begin n_bad++; $display("FAIL t5_err_width: got %0d expected 1", err_cnt); end
    n_cmp++;
    if (other !== 0) begin n_bad++; $display("FAIL t5_err_other: got %0d active cycles expected 0", other); end
    bus_read(32'h0000_0FF0, 4, 4, -1, 0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t5_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t5_mem_kept: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    other = 0;
    @(negedge clock);
    busIn_begin_transaction = 1'b1; busIn_address_data = 32'h1000_0000; busIn_burst_size = 8'd3;
    busIn_read_n_write = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      busIn_begin_transaction = 1'b0;
      if (busOut_data_valid || busOut_end_transaction || busOut_busy || busOut_error ||
          busOut_address_data != 32'h0) other++;
    end
    clear_inputs();
    n_cmp++;
    if (other !== 0) begin n_bad++; $display("FAIL t5_miss_quiet: got %0d active cycles expected 0", other); end
  endtask

`ifdef BUS_SLAVE_ERROR_INJECT_EN
  task automatic test_err_inject;
    logic [31:0] e, o;
    errInject_enable = 1'b1; errInject_beat = 8'd3;
    bus_read(32'h0000_0030, 8, 3, -1, 0);
    errInject_enable = 1'b0; errInject_beat = 8'd0;
    n_cmp++;
    if (rd_err_cycle !== 5) begin n_bad++; $display("FAIL t6_err_cycle: got %0d expected 5", rd_err_cycle); end
    n_cmp++;
    if (rd_valid_cycles !== 3) begin n_bad++; $display("FAIL t6_valid_cycles: got %0d expected 3", rd_valid_cycles); end
    repeat (3) begin
      @(negedge clock);
      if (busOut_end_transaction) rd_end_cycle = 99;
    end
    n_cmp++;
    if (rd_end_cycle !== -1) begin n_bad++; $display("FAIL t6_no_end: got %0d expected -1", rd_end_cycle); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t6_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  task automatic test_reset_mid_write;
    logic [31:0] e, o;
    int i, guard;
    logic hit_busy;
    for (int k = 0; k < 8; k++) wr_q.push_back(32'hA000_0000 + 32'(k));
    bus_write(32'h0000_0320, 4'hF);
    @(negedge clock);
    busIn_begin_transaction = 1'b1; busIn_address_data = 32'h0000_0320; busIn_burst_size = 8'd7;
    busIn_read_n_write = 1'b0; busIn_byte_enables = 4'hF;
    @(negedge clock);
    busIn_begin_transaction = 1'b0; busIn_address_data = '0;
    i = 0; guard = 0; hit_busy = 1'b0;
    while (!hit_busy && guard < 40) begin
      @(negedge clock);
      guard++;
      if (busOut_busy) hit_busy = 1'b1;
      else if (i < 8) begin
        busIn_data_valid   = 1'b1;
        busIn_address_data = 32'hB000_0000 + 32'(i);
        model_mem[200 + i] = 32'hB000_0000 + 32'(i);
        i++;
      end
    end
    n_cmp++;
    if (!hit_busy || i != 4) begin n_bad++; $display("FAIL t7_pre_busy: got busy=%b words=%0d expected 1/4", hit_busy, i); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busOut_data_valid, busOut_end_transaction, busOut_busy, busOut_error} !== 4'b0 ||
        busOut_address_data !== 32'h0) begin
      n_bad++;
      $display("FAIL t7_reset_outputs: got %b/%h expected 0000/0",
               {busOut_data_valid, busOut_end_transaction, busOut_busy, busOut_error}, busOut_address_data);
    end
    for (int k = 4; k < 8; k++) begin
      @(negedge clock);
      if (k == 5) reset = 1'b1;
      busIn_data_valid   = 1'b1;
      busIn_address_data = 32'hB000_0000 + 32'(k);
    end
    @(negedge clock);
    clear_inputs();
    bus_read(32'h0000_0320, 8, 8, -1, 0);
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t7_beats: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL t7_data: got %h expected %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
`ifdef BUS_SLAVE_ERROR_INJECT_EN
    errInject_enable = 1'b0;
    errInject_beat   = 8'd0;
`endif
    test_reset();
    test_write_read();
    test_read_busy();
    test_busy_inject();
    test_byte_enable();
    test_range_error_and_miss();
`ifdef BUS_SLAVE_ERROR_INJECT_EN
    test_err_inject();
`endif
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
